// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART word transmitter among NUM_REQ requesters.
//   clk, rst       : rising-edge clock, asynchronous active-high reset
//   req_i, word_i  : per-requester level request and packed 32-bit word (requester k at [32k+31:32k])
//   ack_o, err_o   : one-cycle completion pulse / timeout flag to the granted requester
//   tx_start_o     : one-cycle start pulse to the word transmitter
//   tx_word_o      : registered word being transmitted
//   tx_done_i      : completion pulse from the word transmitter
//   busy_o         : transaction in progress
//   grant_id_o     : index of the current/last granted requester
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 65535,
    parameter int IDW = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [32*NUM_REQ-1:0]  word_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [NUM_REQ-1:0]     err_o,
    output logic                   tx_start_o,
    output logic [31:0]            tx_word_o,
    input  logic                   tx_done_i,
    output logic                   busy_o,
    output logic [IDW-1:0]         grant_id_o
);
    // A disabled watchdog still needs a legal one-bit timer.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, DONE = 2'd3;
    logic [1:0] state;
    logic [IDW-1:0] rr_ptr, winner;
    logic [TW-1:0] timer;
    logic err_q, timed_out;
    logic [31:0] words [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = word_i[32*g +: 32];
    end
    // Scan offsets from highest to lowest so the smallest offset from rr_ptr wins.
    always_comb begin
        winner = rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_i[(int'(rr_ptr) + i) % NUM_REQ]) winner = IDW'((int'(rr_ptr) + i) % NUM_REQ);
    end
    assign timed_out  = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
    assign busy_o     = state != IDLE;
    assign tx_start_o = state == START;
    assign ack_o      = (state == DONE) ? NUM_REQ'(1) << grant_id_o : '0;
    assign err_o      = err_q ? ack_o : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id_o <= '0;
            tx_word_o  <= '0;
            timer      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_i) begin
                    grant_id_o <= winner;
                    tx_word_o  <= words[winner];
                    err_q      <= 1'b0;
                    state      <= START;
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                // Done is checked first so a coincident limit raises no error.
                WAIT: if (tx_done_i) begin
                    err_q <= 1'b0;
                    state <= DONE;
                end else if (timed_out) begin
                    err_q <= 1'b1;
                    state <= DONE;
                end else if (timer != '1) begin
                    timer <= timer + 1'b1;
                end
                default: begin
                    rr_ptr <= (grant_id_o == IDW'(NUM_REQ - 1)) ? '0 : grant_id_o + 1'b1;
                    err_q  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single UART 32-bit word transmitter among NUM_REQ requesters, e.g. CPU MMIO store path, debug/trace unit and boot monitor. It selects one pending requester, hands its word to the word transmitter with a one-cycle start pulse, and waits for the transmitter's completion pulse. It then acknowledges the requester and advances priority. A watchdog aborts a transaction whose completion never arrives.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 65535, max cycles waited in WAIT for tx_done_i; 0 disables the watchdog
IDW, $clog2(NUM_REQ), width of grant index (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_i  in  NUM_REQ  level request per requester; held until its ack_o pulse
word_i  in  32*NUM_REQ  packed words; requester k at bits [32k+31:32k]; valid while req_i[k]=1
ack_o  out  NUM_REQ  one-cycle completion pulse to granted requester
err_o  out  NUM_REQ  one-cycle timeout flag, coincident with ack_o
tx_start_o  out  1  one-cycle start pulse to word transmitter
tx_word_o  out  32  word to transmit; stable from START until return to IDLE
tx_done_i  in  1  one-cycle pulse from word transmitter when last byte's stop bit finishes
busy_o  out  1  high in START, WAIT, DONE
grant_id_o  out  IDW  index of current/last granted requester

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, grant_id_o=0, tx_word_o=0, timer=0. ack_o, err_o, tx_start_o and busy_o are all 0.
- States: IDLE, START, WAIT, DONE (registered state, Moore outputs plus registered grant/word).
- IDLE: when req_i!=0, select winner = first asserted bit searching upward from rr_ptr with wrap to 0. On the same edge, grant_id_o<=winner, tx_word_o<=word_i[winner], next=START. If req_i==0, stay.
- START: tx_start_o=1 for exactly this cycle. timer<=0. next=WAIT.
- WAIT: tx_done_i sampled only here. If tx_done_i=1, next=DONE with error flag clear. Else if TIMEOUT!=0 and timer==TIMEOUT-1, next=DONE with error flag set. Else timer<=timer+1.
- If tx_done_i and the timeout limit coincide, done wins and no error is raised.
- tx_done_i pulses in IDLE, START or DONE are ignored.
- DONE: ack_o[grant_id_o]=1 and err_o[grant_id_o]=error flag, for one cycle. rr_ptr<=(grant_id_o+1) mod NUM_REQ, wrapping to 0 for non-power-of-2 NUM_REQ. next=IDLE.
- Requester contract: deassert req_i on the edge that samples ack_o. A req still high in IDLE after DONE is treated as a new request.
- Request dropped mid-transaction: the transaction runs to completion and the ack is still issued. Word changes after grant have no effect, because tx_word_o is registered.
- Latency: req_i rises in cycle n while IDLE, then tx_start_o=1 in n+1. If tx_done_i arrives in cycle m, ack_o=1 in m+1. Minimum gap between successive grants is 1 IDLE cycle.
- Timer width is $clog2(TIMEOUT+1) with no wrap-around; the timer saturates at the limit and the compare ends WAIT.
- Reset mid-operation forces IDLE immediately. No ack is issued, and the lost transaction is the requester's responsibility. The word transmitter shares the reset.
- grant_id_o holds its value after DONE until the next grant.

Test Plan:
- Single request: reset, req_i=4'b0100 with word_i[2]=32'hDEADBEEF, tx_done_i 20 cycles after start -> tx_start_o one pulse; tx_word_o=32'hDEADBEEF; grant_id_o=2; ack_o=4'b0100 one cycle after done; err_o=0; busy_o low afterwards.
- Round-robin: req_i=4'b1111 held, each requester dropping its req on its ack -> grants in order 0,1,2,3; rr_ptr wraps to 0.
- Wrap/fairness: after granting 3, req_i=4'b1001 -> grant 0 then 3; persistent req[0] re-asserted never starves req[3].
- Timeout: TIMEOUT=8, never pulse tx_done_i -> ack_o and err_o asserted for the requester exactly 9 cycles after tx_start_o; returns to IDLE.
- Coincidence and stray pulses: tx_done_i on the cycle the timer reaches TIMEOUT-1 -> ack_o with err_o=0; tx_done_i pulsed during IDLE -> no ack_o.
- Reset mid-WAIT: assert rst 5 cycles after start -> outputs 0 immediately, no ack_o; after release, a new req_i=4'b0010 grants requester 1 with rr_ptr=0 priority.
